sad_accum_pipe: RTL

- Parametrised sum-of-absolute-differences accumulator for the motion estimator datapath.
- Each accepted beat carries LANES pixel pairs:
  - R comes from the reference block.
  - S1 or S2 comes from the candidate search window, chosen by S1S2mux.
- Beats are absolute-differenced, summed, and accumulated with saturation over BLOCK_BEATS beats.
- Emits one registered SAD per block with a valid pulse; feeds the comparator that picks the best motion vector.

---
 rtl/sad_accum_pipe_pkg.sv | 19 +
 rtl/sad_accum_pipe_if.sv | 29 ++
 rtl/sad_accum_pipe_lane_tree.sv | 19 +
 rtl/sad_accum_pipe.sv | 118 +++++++++++
 4 files changed

// File: rtl/sad_accum_pipe_pkg.sv
// sad_accum_pipe_pkg: shared defaults, FSM state type and arithmetic helpers for the SAD accumulator
// Package motion_est_pkg: PIX_W_DEF/ACC_W_DEF defaults, sad_state_t, absdiff(), clog2()
package motion_est_pkg;
    localparam int PIX_W_DEF = 8;
    localparam int ACC_W_DEF = 16;

    typedef enum logic {IDLE, ACCUM} sad_state_t;

    // Unsigned |a-b|: larger minus smaller, so no two's-complement wrap.
    function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
        return a > b ? a - b : b - a;
    endfunction

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/sad_accum_pipe_if.sv
// sad_accum_pipe_if: beat input and block result bundle for sad_accum_pipe
// master drives in_valid/newDist/S1S2mux/R/S1/S2; slave drives out_valid/Accumulate/saturated/busy/best_sad/best_idx
interface sad_accum_pipe_if #(
    parameter int PIX_W = motion_est_pkg::PIX_W_DEF,
    parameter int LANES = 4,
    parameter int ACC_W = motion_est_pkg::ACC_W_DEF
);
    logic                   in_valid;
    logic                   newDist;
    logic                   S1S2mux;
    logic [LANES*PIX_W-1:0] R;
    logic [LANES*PIX_W-1:0] S1;
    logic [LANES*PIX_W-1:0] S2;
    logic                   out_valid;
    logic [ACC_W-1:0]       Accumulate;
    logic                   saturated;
    logic                   busy;
    logic [ACC_W-1:0]       best_sad;
    logic [15:0]            best_idx;

    modport master (
        output in_valid, newDist, S1S2mux, R, S1, S2,
        input  out_valid, Accumulate, saturated, busy, best_sad, best_idx
    );
    modport slave (
        input  in_valid, newDist, S1S2mux, R, S1, S2,
        output out_valid, Accumulate, saturated, busy, best_sad, best_idx
    );
endinterface

// File: rtl/sad_accum_pipe_lane_tree.sv
// sad_lane_tree: combinational per-lane absolute difference summed across LANES lanes
// Ports: r, s (LANES*PIX_W packed pixels, lane i at [i*PIX_W +: PIX_W]); sum (SUM_W, full precision)
module sad_lane_tree
    import motion_est_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int LANES = 4,
    parameter int SUM_W = PIX_W + clog2(LANES)
) (
    input  logic [LANES*PIX_W-1:0] r,
    input  logic [LANES*PIX_W-1:0] s,
    output logic [SUM_W-1:0]       sum
);
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++)
            sum = sum + SUM_W'(absdiff(32'(r[i*PIX_W +: PIX_W]), 32'(s[i*PIX_W +: PIX_W])));
    end
endmodule

// File: rtl/sad_accum_pipe.sv
// sad_accum_pipe: pipelined, saturating sum-of-absolute-differences accumulator over BLOCK_BEATS beats
// Ports: clock, reset (sync, active-high); bus (sad_accum_pipe_if.slave):
//   in:  in_valid, newDist (first beat of block), S1S2mux (1=S1, 0=S2), R, S1, S2
//   out: out_valid (1-cycle pulse), Accumulate, saturated, busy, best_sad, best_idx
// Optional: define MIN_TRACK_EN to track the minimum block SAD and its block ordinal since reset;
//   otherwise best_sad/best_idx are tied to 0.
module sad_accum_pipe
    import motion_est_pkg::*;
#(
    parameter int PIX_W       = PIX_W_DEF,
    parameter int LANES       = 4,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int BLOCK_BEATS = 64
) (
    input logic             clock,
    input logic             reset,
    sad_accum_pipe_if.slave bus
);
    localparam int SW = PIX_W + clog2(LANES);
    localparam int XW = (ACC_W > SW ? ACC_W : SW) + 1;
    localparam int CW = clog2(BLOCK_BEATS) + 1;
    localparam logic [XW-1:0] ACC_MAX = (XW'(1) << ACC_W) - XW'(1);

    sad_state_t       state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             accept, first, last;
    logic [SW-1:0]    lane_sum, s1_sum;
    logic             s1_valid, s1_first, s1_last;
    logic             s2_valid, s2_last;
    logic [ACC_W-1:0] acc;
    logic             sat, sat_n;
    logic [XW-1:0]    sum_x;

    sad_lane_tree #(.PIX_W(PIX_W), .LANES(LANES), .SUM_W(SW)) u_tree (
        .r  (bus.R),
        .s  (bus.S1S2mux ? bus.S1 : bus.S2),
        .sum(lane_sum)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // newDist restarts a block from any state, which is also how an abort is handled.
    always_comb begin
        accept  = bus.in_valid && (state == ACCUM || bus.newDist);
        first   = accept && bus.newDist;
        last    = first ? (BLOCK_BEATS == 1) : accept && cnt == CW'(BLOCK_BEATS - 1);
        state_n = !accept ? state : first ? (BLOCK_BEATS > 1 ? ACCUM : IDLE) : last ? IDLE : ACCUM;
        cnt_n   = !accept ? cnt : first ? CW'(1) : last ? '0 : cnt + 1'b1;
    end

    // One extra bit of headroom detects overflow; the sticky bit keeps acc pinned once clipped.
    assign sum_x = (s1_first ? '0 : XW'(acc)) + XW'(s1_sum);
    assign sat_n = (sat && !s1_first) || sum_x > ACC_MAX;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid       <= 1'b0;
            s1_first       <= 1'b0;
            s1_last        <= 1'b0;
            s1_sum         <= '0;
            s2_valid       <= 1'b0;
            s2_last        <= 1'b0;
            acc            <= '0;
            sat            <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.Accumulate <= '0;
            bus.saturated  <= 1'b0;
        end else begin
            s1_valid      <= accept;
            s1_first      <= first;
            s1_last       <= last;
            s1_sum        <= lane_sum;
            s2_valid      <= s1_valid;
            s2_last       <= s1_valid && s1_last;
            bus.out_valid <= s2_last;
            if (s1_valid) begin
                acc <= sat_n ? '1 : sum_x[ACC_W-1:0];
                sat <= sat_n;
            end
            if (s2_last) begin
                bus.Accumulate <= acc;
                bus.saturated  <= sat;
            end
        end
    end

    assign bus.busy = state == ACCUM || s1_valid || s2_valid;

`ifdef MIN_TRACK_EN
    logic [15:0] blk_cnt;

    // Strict compare so a tie keeps the earlier block.
    always_ff @(posedge clock) begin
        if (reset) begin
            blk_cnt      <= '0;
            bus.best_sad <= '1;
            bus.best_idx <= '0;
        end else if (s2_last) begin
            blk_cnt <= blk_cnt + 16'd1;
            if (acc < bus.best_sad) begin
                bus.best_sad <= acc;
                bus.best_idx <= blk_cnt;
            end
        end
    end
`else
    assign bus.best_sad = '0;
    assign bus.best_idx = '0;
`endif
endmodule
